// File: rtl/pong_pkg.sv
// Shared geometry, game-state/phase enums and the per-frame game record for the pong controller.
package pong_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int PADDLE_H     = 64;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_X_L   = 16;
  localparam int BALL         = 8;
  localparam int PADDLE_STEP  = 4;
  localparam int SERVE_FRAMES = 60;
  localparam int SCORE_MAX    = 9;

  localparam logic [9:0] PAD_STEP_V = 10'(PADDLE_STEP);
  localparam logic [9:0] PAD_Y_MAX  = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] PAD_Y_C    = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] BALL_X_C   = 10'((H_ACTIVE - BALL) / 2);
  localparam logic [9:0] BALL_Y_C   = 10'((V_ACTIVE - BALL) / 2);
  localparam logic [9:0] BALL_X_MAX = 10'(H_ACTIVE - BALL);
  localparam logic [9:0] BALL_Y_MAX = 10'(V_ACTIVE - BALL);
  localparam logic [9:0] PADDLE_X_R = 10'(H_ACTIVE - PADDLE_X_L - PADDLE_W);
  localparam logic [9:0] L_FACE     = 10'(PADDLE_X_L + PADDLE_W);
  localparam logic [9:0] R_FACE     = PADDLE_X_R - 10'(BALL);
  localparam logic [5:0] SERVE_CNT  = 6'(SERVE_FRAMES);
  localparam logic [3:0] SCORE_WIN  = 4'(SCORE_MAX);

  typedef enum logic [1:0] {GS_SERVE = 2'd0, GS_PLAY = 2'd1, GS_GAMEOVER = 2'd2} game_state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_PADDLE, PH_BALL, PH_COMMIT} phase_e;

  // One complete coordinate/score set; dxn/dyn set means moving left/up.
  typedef struct packed {
    logic [9:0]  bx;
    logic [9:0]  by;
    logic [9:0]  pl;
    logic [9:0]  pr;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic        dxn;
    logic        dyn;
    game_state_e gs;
    logic [5:0]  cnt;
  } game_t;

  function automatic game_t game_init();
    game_t g;
    g.bx  = BALL_X_C;
    g.by  = BALL_Y_C;
    g.pl  = PAD_Y_C;
    g.pr  = PAD_Y_C;
    g.sl  = '0;
    g.sr  = '0;
    g.dxn = 1'b0;
    g.dyn = 1'b0;
    g.gs  = GS_SERVE;
    g.cnt = SERVE_CNT;
    return g;
  endfunction

  function automatic logic signed [10:0] s11(input logic [9:0] v);
    return $signed({1'b0, v});
  endfunction

  function automatic logic v_overlap(input logic [9:0] by, input logic [9:0] py);
    return ({1'b0, by} + 11'(BALL) > {1'b0, py}) && ({1'b0, by} < {1'b0, py} + 11'(PADDLE_H));
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == SCORE_WIN) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle_step.sv
// Next top edge of one paddle: one PADDLE_STEP per frame, clamped to the visible field.
module pong_paddle_step
  import pong_pkg::*;
(
  input  logic [9:0] y_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [9:0] y_o
);

  always_comb begin
    y_o = y_i;
    if (up_i && !down_i)
      y_o = (y_i < PAD_STEP_V) ? '0 : y_i - PAD_STEP_V;
    else if (down_i && !up_i)
      y_o = (y_i > PAD_Y_MAX - PAD_STEP_V) ? PAD_Y_MAX : y_i + PAD_STEP_V;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame pong game controller: paddle, ball, collision and score update committed once per frame.
// Build option PONG_AUTO_RIGHT_EN: right paddle tracks the ball instead of its buttons.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  input  logic       score_reset,
  input  logic [1:0] speed,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_l_y,
  output logic [9:0] paddle_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] game_state,
  output logic       busy,
  output logic       hit
);

  phase_e phase_q, phase_d;
  game_t  cur_q, cur_d, wrk_q, wrk_d;
  logic   whit_q, whit_d, hit_q, hit_d, busy_q, busy_d;
  logic [9:0] pl_nxt, pr_nxt;
  logic   r_up, r_dn;
  logic signed [10:0] step, nx, ny;

`ifdef PONG_AUTO_RIGHT_EN
  logic [10:0] ball_c, pad_c;
  assign ball_c = {1'b0, cur_q.by} + 11'(BALL / 2);
  assign pad_c  = {1'b0, cur_q.pr} + 11'(PADDLE_H / 2);
  assign r_up   = (ball_c + 11'(PADDLE_STEP)) < pad_c;
  assign r_dn   = ball_c > (pad_c + 11'(PADDLE_STEP));
`else
  assign r_up = right_up;
  assign r_dn = right_down;
`endif

  pong_paddle_step u_pad_l (.y_i(cur_q.pl), .up_i(left_up), .down_i(left_down), .y_o(pl_nxt));
  pong_paddle_step u_pad_r (.y_i(cur_q.pr), .up_i(r_up),    .down_i(r_dn),      .y_o(pr_nxt));

  always_comb begin
    phase_d = phase_q;
    cur_d   = cur_q;
    wrk_d   = wrk_q;
    whit_d  = whit_q;
    hit_d   = 1'b0;
    step    = $signed({9'd0, speed}) + 11'sd1;
    nx      = cur_q.dxn ? s11(cur_q.bx) - step : s11(cur_q.bx) + step;
    ny      = cur_q.dyn ? s11(cur_q.by) - step : s11(cur_q.by) + step;
    case (phase_q)
      PH_IDLE: if (frame_tick) phase_d = PH_PADDLE;
      PH_PADDLE: begin
        wrk_d    = cur_q;
        wrk_d.pl = pl_nxt;
        wrk_d.pr = pr_nxt;
        phase_d  = PH_BALL;
      end
      PH_BALL: begin
        whit_d  = 1'b0;
        phase_d = PH_COMMIT;
        case (cur_q.gs)
          GS_SERVE: begin
            wrk_d.bx = BALL_X_C;
            wrk_d.by = BALL_Y_C;
            if (cur_q.cnt == '0) wrk_d.gs = GS_PLAY;
            else                 wrk_d.cnt = cur_q.cnt - 6'd1;
          end
          GS_PLAY: begin
            if (ny < 11'sd0) begin
              wrk_d.by = '0; wrk_d.dyn = 1'b0; whit_d = 1'b1;
            end else if (ny > s11(BALL_Y_MAX)) begin
              wrk_d.by = BALL_Y_MAX; wrk_d.dyn = 1'b1; whit_d = 1'b1;
            end else begin
              wrk_d.by = ny[9:0];
            end
            // Paddle faces are checked before the goal lines so a save wins over a score.
            if (cur_q.dxn && nx <= s11(L_FACE) && v_overlap(cur_q.by, cur_q.pl)) begin
              wrk_d.bx = L_FACE; wrk_d.dxn = 1'b0; whit_d = 1'b1;
            end else if (!cur_q.dxn && nx >= s11(R_FACE) && v_overlap(cur_q.by, cur_q.pr)) begin
              wrk_d.bx = R_FACE; wrk_d.dxn = 1'b1; whit_d = 1'b1;
            end else if (nx < 11'sd0 || nx > s11(BALL_X_MAX)) begin
              if (nx < 11'sd0) begin
                wrk_d.sr = sat_inc(cur_q.sr); wrk_d.dxn = 1'b1;
              end else begin
                wrk_d.sl = sat_inc(cur_q.sl); wrk_d.dxn = 1'b0;
              end
              wrk_d.bx  = BALL_X_C;
              wrk_d.by  = BALL_Y_C;
              wrk_d.cnt = SERVE_CNT;
              wrk_d.gs  = (wrk_d.sl == SCORE_WIN || wrk_d.sr == SCORE_WIN) ? GS_GAMEOVER : GS_SERVE;
            end else begin
              wrk_d.bx = nx[9:0];
            end
          end
          default: begin
            wrk_d.bx = BALL_X_C;
            wrk_d.by = BALL_Y_C;
          end
        endcase
      end
      PH_COMMIT: begin
        cur_d   = wrk_q;
        hit_d   = whit_q;
        phase_d = PH_IDLE;
      end
    endcase
    // Match clear drops any half-built frame; paddles and direction keep their committed values.
    if (score_reset) begin
      cur_d     = cur_q;
      cur_d.bx  = BALL_X_C;
      cur_d.by  = BALL_Y_C;
      cur_d.sl  = '0;
      cur_d.sr  = '0;
      cur_d.gs  = GS_SERVE;
      cur_d.cnt = SERVE_CNT;
      hit_d     = 1'b0;
      phase_d   = PH_IDLE;
    end
    busy_d = (phase_d != PH_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cur_q   <= game_init();
      wrk_q   <= game_init();
      whit_q  <= 1'b0;
      hit_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      wrk_q   <= wrk_d;
      whit_q  <= whit_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
    end
  end

  assign ball_x     = cur_q.bx;
  assign ball_y     = cur_q.by;
  assign paddle_l_y = cur_q.pl;
  assign paddle_r_y = cur_q.pr;
  assign score_l    = cur_q.sl;
  assign score_r    = cur_q.sr;
  assign game_state = cur_q.gs;
  assign busy       = busy_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised frame stimulus against a rule-level game model; a monitor checks each committed frame.
module tb_pong_game_ctrl;

  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, score_reset = 1'b0;
  logic left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [3:0] score_l, score_r;
  logic [1:0] game_state;
  logic busy, hit;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
    .score_reset(score_reset), .speed(speed),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state), .busy(busy), .hit(hit)
  );

  typedef struct {int bx; int by; int pl; int pr; int sl; int sr; int gs; int hit; int blen;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  // Reference game: plain integer rules, 0=SERVE 1=PLAY 2=GAMEOVER, dx/dy are +1/-1.
  int m_bx = 316, m_by = 236, m_pl = 208, m_pr = 208, m_sl = 0, m_sr = 0;
  int m_gs = 0, m_cnt = 60, m_dx = 1, m_dy = 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int pmove(input int p, input bit up, input bit dn);
    if (up && !dn) return (p < 4) ? 0 : p - 4;
    if (dn && !up) return (p > 412) ? 416 : p + 4;
    return p;
  endfunction

  function automatic bit ovl(input int by, input int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_frame(input bit lu, input bit ld, input bit ru, input bit rd,
                             input int spd, output exp_t e);
    int nx, ny, v;
    bit h;
    h = 0;
    v = spd + 1;
    if (m_gs == 0) begin
      m_bx = 316; m_by = 236;
      if (m_cnt == 0) m_gs = 1; else m_cnt--;
    end else if (m_gs == 1) begin
      nx = m_bx + m_dx * v;
      ny = m_by + m_dy * v;
      if (ny < 0)   begin ny = 0;   m_dy = 1;  h = 1; end
      if (ny > 472) begin ny = 472; m_dy = -1; h = 1; end
      if (m_dx < 0 && nx <= 24 && ovl(m_by, m_pl)) begin nx = 24; m_dx = 1; h = 1; end
      else if (m_dx > 0 && nx >= 608 && ovl(m_by, m_pr)) begin nx = 608; m_dx = -1; h = 1; end
      else if (nx < 0 || nx > 632) begin
        if (nx < 0) begin m_sr = (m_sr < 9) ? m_sr + 1 : 9; m_dx = -1; end
        else        begin m_sl = (m_sl < 9) ? m_sl + 1 : 9; m_dx = 1;  end
        nx = 316; ny = 236; m_cnt = 60;
        m_gs = (m_sl == 9 || m_sr == 9) ? 2 : 0;
      end
      m_bx = nx; m_by = ny;
    end
    m_pl = pmove(m_pl, lu, ld);
    m_pr = pmove(m_pr, ru, rd);
    e = '{m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_gs, int'(h), 3};
  endtask

  task automatic do_frame(input bit lu, input bit ld, input bit ru, input bit rd,
                          input int spd, input bit extra);
    exp_t e;
    @(posedge clk); #1;
    left_up = lu; left_down = ld; right_up = ru; right_down = rd;
    speed = 2'(spd);
    frame_tick = 1'b1;
    model_frame(lu, ld, ru, rd, spd, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    frame_tick = extra;   // a tick while busy must be dropped
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic abort_frame();
    exp_t e;
    @(posedge clk); #1;
    left_down = 1'b1; right_up = 1'b1; frame_tick = 1'b1;
    m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_gs = 0; m_cnt = 60;
    e = '{m_bx, m_by, m_pl, m_pr, 0, 0, 0, 0, 1};
    exp_q.push_back(e);
    @(posedge clk); #1;
    frame_tick = 1'b0; score_reset = 1'b1;
    @(posedge clk); #1;
    score_reset = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Monitor: a falling busy marks a finished (or aborted) update.
  initial begin
    bit pb, hchk;
    int blen;
    exp_t e;
    pb = 0; hchk = 0; blen = 0;
    forever begin
      @(negedge clk);
      if (hchk) begin chk("hit_width", int'(hit), 0); hchk = 0; end
      if (busy) blen++;
      else if (pb) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_update: got busy pulse, expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("ball_x", int'(ball_x), e.bx);
          chk("ball_y", int'(ball_y), e.by);
          chk("paddle_l_y", int'(paddle_l_y), e.pl);
          chk("paddle_r_y", int'(paddle_r_y), e.pr);
          chk("score_l", int'(score_l), e.sl);
          chk("score_r", int'(score_r), e.sr);
          chk("game_state", int'(game_state), e.gs);
          chk("hit", int'(hit), e.hit);
          chk("busy_len", blen, e.blen);
          hchk = 1;
        end
        blen = 0;
      end
      pb = busy;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ball_x", int'(ball_x), 316);
    chk("rst_ball_y", int'(ball_y), 236);
    chk("rst_paddle_l", int'(paddle_l_y), 208);
    chk("rst_paddle_r", int'(paddle_r_y), 208);
    chk("rst_scores", int'(score_l) + int'(score_r), 0);
    chk("rst_state", int'(game_state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(hit), 0);

    do_frame(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      do_frame(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), 3, 0);
    for (int i = 0; i < 5; i++)
      do_frame(1, 1, 0, 1, 3, 0);

    // Left paddle mostly parked at the top, right mostly at the bottom, so points get scored.
    n = 0;
    while (m_gs != 2 && n < 3800) begin
      do_frame($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0,
               $urandom_range(1, 3), $urandom_range(0, 7) == 0);
      n++;
    end
    for (int i = 0; i < 5; i++)
      do_frame($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 3), 0);

    abort_frame();
    for (int i = 0; i < 70; i++)
      do_frame($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) == 0);

    repeat (10) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
